// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pipeline: pixel type and filter mode encodings.
package conv_pkg;

  localparam int PIXEL_WIDTH_DEF = 8;

  typedef logic [PIXEL_WIDTH_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    SHARPEN = 2'd0,
    GAUSS   = 2'd1,
    EDGE    = 2'd2,
    PASS    = 2'd3
  } conv_mode_t;

endpackage

// File: rtl/conv_line_ram.sv
// One image row of pixel storage: combinational read of the addressed entry,
// synchronous write, so a same-cycle read returns the value before the write.
module conv_line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_row_feeder.sv
// Turns a raster pixel stream into columns of three vertically aligned pixels.
// Build option ZERO_PAD_EN: also emit rows 0 and 1 with the missing rows zeroed.
module conv_row_feeder import conv_pkg::*; #(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_sof,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic [CW-1:0]          m_col,
  output logic [RW-1:0]          m_row,
  output logic                   m_sof,
  output logic                   m_eof
);

  logic [CW-1:0] col, pos_col, col_next;
  logic [RW-1:0] row, pos_row, row_next;
  logic accept, emit, last_col, last_row, first_pos;
  logic [PIXEL_WIDTH-1:0] line0_rd, line1_rd, top_val, mid_val;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of where the counters are.
  assign pos_col  = s_sof ? '0 : col;
  assign pos_row  = s_sof ? '0 : row;
  assign last_col = (pos_col == CW'(IMG_WIDTH - 1));
  assign last_row = (pos_row == RW'(IMG_HEIGHT - 1));

  always_comb begin
    col_next = pos_col + CW'(1);
    row_next = pos_row;
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? '0 : pos_row + RW'(1);
    end
  end

  conv_line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_line0 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_col),
    .wdata (s_data),
    .rdata (line0_rd)
  );

  conv_line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_line1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_col),
    .wdata (line0_rd),
    .rdata (line1_rd)
  );

`ifdef ZERO_PAD_EN
  // Rows above the image are treated as zero, so every row emits.
  assign emit      = 1'b1;
  assign top_val   = (pos_row < RW'(2)) ? '0 : line1_rd;
  assign mid_val   = (pos_row == '0) ? '0 : line0_rd;
  assign first_pos = (pos_row == '0) && (pos_col == '0);
`else
  assign emit      = (pos_row >= RW'(2));
  assign top_val   = line1_rd;
  assign mid_val   = line0_rd;
  assign first_pos = (pos_row == RW'(2)) && (pos_col == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      m_valid <= 1'b0;
      pix_top <= '0;
      pix_mid <= '0;
      pix_bot <= '0;
      m_col   <= '0;
      m_row   <= '0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else begin
      if (accept) begin
        col <= col_next;
        row <= row_next;
      end
      // Output stage only loads on an emitting accept, so held beats stay stable.
      if (accept && emit) begin
        m_valid <= 1'b1;
        pix_top <= top_val;
        pix_mid <= mid_val;
        pix_bot <= s_data;
        m_col   <= pos_col;
        m_row   <= pos_row;
        m_sof   <= first_pos;
        m_eof   <= last_row && last_col;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Self-checking bench for conv_row_feeder on a 4x4 image (also valid with ZERO_PAD_EN).
module tb_conv_row_feeder;

  localparam int W = 4;
  localparam int H = 4;
`ifdef ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic [1:0] col;
    logic [1:0] row;
    logic       sof;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_sof = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] pix_top, pix_mid, pix_bot;
  logic [1:0] m_col, m_row;
  logic       m_sof, m_eof;

  int total = 0;
  int bad = 0;
  int cycles = 0;

  beat_t exp_q[$];
  beat_t got[$];
  int    img[H][W];
  int    mr = 0;
  int    mc = 0;
  bit    held = 0;
  beat_t held_beat;

  conv_row_feeder #(.PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sof   (s_sof),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .pix_top (pix_top),
    .pix_mid (pix_mid),
    .pix_bot (pix_bot),
    .m_col   (m_col),
    .m_row   (m_row),
    .m_sof   (m_sof),
    .m_eof   (m_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycles++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: pixels are stored by (row,col) of the image; an output column is
  // the two pixels above the accepted one in the same column.
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{pix_top, pix_mid, pix_bot, m_col, m_row, m_sof, m_eof};
    if (!rst_n) begin
      exp_q.delete();
      mr = 0;
      mc = 0;
      held = 0;
    end else begin
      if (held) checkOutput("hold_stable", 32'(cur), 32'(held_beat));
      if (m_valid && !m_ready) checkOutput("s_ready_held", 32'(s_ready), 32'd0);
      if (!m_valid) checkOutput("s_ready_idle", 32'(s_ready), 32'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) checkOutput("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          checkOutput("beat", 32'(cur), 32'(e));
        end
        got.push_back(cur);
      end
      held = m_valid && !m_ready;
      held_beat = cur;
      if (s_valid && s_ready) begin
        if (s_sof) begin
          mr = 0;
          mc = 0;
        end
        img[mr][mc] = int'(s_data);
        if (PAD || mr >= 2) begin
          e.top = (mr >= 2) ? 8'(img[mr-2][mc]) : 8'h00;
          e.mid = (mr >= 1) ? 8'(img[mr-1][mc]) : 8'h00;
          e.bot = s_data;
          e.col = 2'(mc);
          e.row = 2'(mr);
          e.sof = (mc == 0) && (mr == (PAD ? 0 : 2));
          e.eof = (mc == W - 1) && (mr == H - 1);
          exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic sof);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic sendPixels(input int r0, input int c0, input int count);
    int r, c;
    r = r0;
    c = c0;
    for (int i = 0; i < count; i++) begin
      applyStimulus(8'(16 * r + c), (r == 0) && (c == 0));
      c++;
      if (c == W) begin
        c = 0;
        r++;
      end
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t0;
    bit seen;
    bit done_flag;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_pix", {8'h00, pix_top, pix_mid, pix_bot}, 32'd0);
    checkOutput("rst_pos", {28'd0, m_col, m_row}, 32'd0);
    checkOutput("rst_flags", {30'd0, m_sof, m_eof}, 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] full frame, m_ready=1");
    got.delete();
    t0 = cycles;
    sendPixels(0, 0, 16);
    checkOutput("throughput_cycles", 32'(cycles - t0), 32'd16);
    drain();
    checkOutput("frame_beats", 32'(got.size()), PAD ? 32'd16 : 32'd8);
    if (PAD) begin
      checkOutput("first_beat", 32'(got[0]), 32'({8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, 1'b0}));
      checkOutput("beat_r1c2", 32'(got[6]), 32'({8'h00, 8'h02, 8'h12, 2'd2, 2'd1, 1'b0, 1'b0}));
    end else begin
      checkOutput("first_beat", 32'(got[0]), 32'({8'h00, 8'h10, 8'h20, 2'd0, 2'd2, 1'b1, 1'b0}));
    end
    checkOutput("last_beat", 32'(got[got.size()-1]),
                32'({8'h13, 8'h23, 8'h33, 2'd3, 2'd3, 1'b0, 1'b1}));

    $display("[TB] backpressure at (2,1)");
    got.delete();
    seen = 0;
    fork
      sendPixels(0, 0, 16);
      begin
        for (int n = 0; n < 200 && !seen; n++) begin
          @(posedge clk);
          #1;
          if (m_valid && m_row == 2'd2 && m_col == 2'd1) seen = 1;
        end
        if (!seen) checkOutput("bp_beat_seen", 32'd0, 32'd1);
        else begin
          m_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
            checkOutput("bp_pix", {8'h00, pix_top, pix_mid, pix_bot}, 32'h0001_1121);
            @(posedge clk);
            #1;
          end
          m_ready = 1'b1;
        end
      end
    join
    drain();
    checkOutput("bp_beats", 32'(got.size()), PAD ? 32'd16 : 32'd8);

    $display("[TB] s_sof restart at (2,2)");
    got.delete();
    sendPixels(0, 0, 10);
    sendPixels(0, 0, 8);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sof_silent_beats", 32'(got.size()), PAD ? 32'd18 : 32'd2);
    sendPixels(2, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sof_ninth_count", 32'(got.size()), PAD ? 32'd19 : 32'd3);
    checkOutput("sof_restart_beat", {26'd0, got[PAD ? 10 : 2].col, got[PAD ? 10 : 2].row,
                                     got[PAD ? 10 : 2].sof, 1'b0},
                {26'd0, 2'd0, PAD ? 2'd0 : 2'd2, 1'b1, 1'b0});
    sendPixels(2, 1, 7);
    drain();
    checkOutput("sof_total_beats", 32'(got.size()), PAD ? 32'd26 : 32'd10);
    checkOutput("sof_last_eof", 32'(got[got.size()-1].eof), 32'd1);

    $display("[TB] reset mid-row at (3,1)");
    got.delete();
    sendPixels(0, 0, 13);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_pos", {28'd0, m_col, m_row}, 32'd0);
    checkOutput("mid_rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    got.delete();
    sendPixels(0, 0, 16);
    drain();
    checkOutput("post_rst_beats", 32'(got.size()), PAD ? 32'd16 : 32'd8);
    checkOutput("post_rst_sof", 32'(got[0].sof), 32'd1);

    $display("[TB] random valid/ready, random data");
    got.delete();
    done_flag = 0;
    fork
      begin
        for (int f = 0; f < 5; f++)
          for (int i = 0; i < W * H; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            applyStimulus(8'($urandom), (i == 0) && (f % 2 == 0));
          end
        done_flag = 1;
      end
      begin
        while (!done_flag) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    drain();
    checkOutput("random_beats", 32'(got.size()), PAD ? 32'd80 : 32'd40);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
